shared_divider_sched: RTL and testbench
=======================================

SHARED_DIVIDER_SCHED -- requirements
Module: shared_divider_sched

Interface
REQ-001 Parameter M, default 8, dividend width in bits.
REQ-002 Parameter N, default 4, divisor width in bits; M > N >= 1 SHALL hold.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1 each  requester k presents an operation.
REQ-006 req0_ready / req1_ready  output  1 each  operation from requester k accepted this cycle.
REQ-007 req0_dividend / req1_dividend  input  M each  dividend of requester k.
REQ-008 req0_divisor / req1_divisor  input  N each  divisor of requester k.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer takes result.
REQ-011 resp_id  output  1  requester that owns the result (0 or 1).
REQ-012 quotient  output  M-N+1  unsigned quotient.
REQ-013 remainder  output  N  unsigned remainder.
REQ-014 err  output  1  divide-by-zero or quotient overflow.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-017 In IDLE, the grant SHALL go to the only valid requester; if both are valid, it SHALL go to the one not granted last (round-robin).
REQ-018 The last-grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-019 reqk_ready SHALL be combinational, high only when the state is IDLE, requester k is granted and reqk_valid is high; at most one ready is high per cycle.
REQ-020 On a handshake, the block SHALL capture dividend, divisor and id, update last-grant, and leave IDLE at the next edge.
REQ-021 Error check at accept: err SHALL be set if the divisor is 0, or if the dividend >= (divisor << (M-N+1)) computed at M+1 bits.
REQ-022 On error, the next state SHALL be DONE, with quotient all ones, remainder 0 and err=1.
REQ-023 Otherwise, the next state SHALL be CALC with bit index i=M-N and err=0.
REQ-024 Each CALC cycle SHALL perform one restoring step: if (divisor<<i) <= the partial remainder, then quotient[i]=1 and partial -= divisor<<i; else quotient[i]=0.
REQ-025 After the step at i=0, the state SHALL go to DONE; CALC SHALL last exactly M-N+1 cycles.
REQ-026 remainder SHALL equal the final partial remainder, which is < divisor and fits in N bits.
REQ-027 Latency, with the handshake in cycle 0: resp_valid SHALL rise in cycle M-N+2 (cycle 6 at defaults); on the error path it SHALL rise in cycle 1.
REQ-028 In DONE, resp_valid=1, and resp_id, quotient, remainder and err SHALL hold stable until a cycle with resp_ready=1.
REQ-029 The DONE-to-IDLE transition SHALL happen at the edge following the response handshake; no new request is accepted in that same cycle.
REQ-030 Requests arriving while busy SHALL see ready=0 and SHALL wait; the block never drops or reorders an accepted operation.
REQ-031 Requester inputs changing after acceptance SHALL NOT affect the operation in flight.
REQ-032 resp_ready asserted outside DONE SHALL be ignored.

Reset
REQ-033 While rst=1 at an edge, the state SHALL go to IDLE with resp_valid=0, busy=0, quotient=0, remainder=0, err=0, resp_id=0 and last-grant=1.
REQ-034 Reset in CALC or DONE SHALL abort the operation with no response emitted.
REQ-035 reqk_ready SHALL be 0 during any cycle in which rst=1.

Verification (M=8, N=4)
REQ-036 req0 200/7, resp_ready=1 -> req0_ready in cycle 0, resp_valid in cycle 6, quotient=28, remainder=4, err=0, resp_id=0.
REQ-037 req1 250/3 -> err=1, quotient=31, remainder=0, resp_valid in cycle 1.
REQ-038 req0 divisor 0 -> err=1, quotient=31, remainder=0, resp_valid in cycle 1.
REQ-039 Both requesters valid continuously after reset (req0 100/9, req1 45/6) -> req0 served first (q=11, r=1), then req1 (q=7, r=3), then req0 again.
REQ-040 resp_ready held 0 for 10 cycles in DONE -> outputs stable, busy=1, no ready asserted; release -> IDLE at the next edge.
REQ-041 rst pulsed in the third CALC cycle -> next cycle IDLE, resp_valid=0, and the pending requester is re-accepted fresh.

Source files
------------

// File: rtl/shared_divider_sched.sv
// shared_divider_sched
//   Two requesters share one restoring divider. A round-robin arbiter picks a
//   requester in IDLE, the operands are captured on the handshake, and the
//   quotient is produced MSB-first, one bit per CALC cycle. The result is held
//   in DONE until the consumer takes it.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqK_valid / reqK_ready   request handshake for requester K (ready is combinational)
//   reqK_dividend [M-1:0]     dividend of requester K
//   reqK_divisor  [N-1:0]     divisor of requester K
//   resp_valid / resp_ready   response handshake
//   resp_id                   requester that owns the response
//   quotient [M-N:0]          unsigned quotient (all ones on error)
//   remainder [N-1:0]         unsigned remainder (zero on error)
//   err                       divide-by-zero or quotient overflow
//   busy                      block is not in IDLE
module shared_divider_sched #(
  parameter int M = 8,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [M-1:0] req0_dividend,
  input  logic [N-1:0] req0_divisor,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [M-1:0] req1_dividend,
  input  logic [N-1:0] req1_divisor,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [M-N:0] quotient,
  output logic [N-1:0] remainder,
  output logic         err,
  output logic         busy
);

  localparam int QW = M - N + 1;
  localparam int IW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic          r_last_grant;
  logic          r_id;
  logic [N-1:0]  r_divisor;
  logic [M-1:0]  r_partial;
  logic [QW-1:0] r_quot;
  logic          r_err;
  logic [IW-1:0] r_idx;

  logic          w_idle;
  logic          w_grant;
  logic          w_accept;
  logic [M-1:0]  w_dividend;
  logic [N-1:0]  w_divisor;
  logic [M:0]    w_limit;
  logic          w_acc_err;
  logic [M-1:0]  w_shifted;
  logic          w_fits;

  // Round-robin: a lone requester always wins; on a tie the requester that
  // was not granted last wins. r_last_grant resets to 1 so requester 0 takes
  // the first tie.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_idle     = (r_state == IDLE);
  assign req0_ready = !rst && w_idle && !w_grant && req0_valid;
  assign req1_ready = !rst && w_idle &&  w_grant && req1_valid;
  assign w_accept   = req0_ready | req1_ready;

  assign w_dividend = w_grant ? req1_dividend : req0_dividend;
  assign w_divisor  = w_grant ? req1_divisor  : req0_divisor;

  // The quotient only fits in QW bits when dividend < divisor * 2^QW.
  // Concatenation gives divisor << QW at exactly M+1 bits.
  assign w_limit   = {w_divisor, {QW{1'b0}}};
  assign w_acc_err = (w_divisor == '0) || ({1'b0, w_dividend} >= w_limit);

  // Because the overflow case was rejected at accept, divisor << idx never
  // exceeds M bits for any idx <= M-N.
  assign w_shifted = M'(r_divisor) << r_idx;
  assign w_fits    = (w_shifted <= r_partial);

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = w_acc_err ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_idx == '0) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: operand capture on accept, one restoring step per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_divisor    <= '0;
      r_partial    <= '0;
      r_quot       <= '0;
      r_err        <= 1'b0;
      r_idx        <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_grant;
      r_id         <= w_grant;
      r_divisor    <= w_divisor;
      r_err        <= w_acc_err;
      r_idx        <= IW'(M - N);
      if (w_acc_err) begin
        r_quot    <= '1;
        r_partial <= '0;
      end else begin
        r_quot    <= '0;
        r_partial <= w_dividend;
      end
    end else if (r_state == CALC) begin
      r_quot[r_idx] <= w_fits;
      if (w_fits) begin
        r_partial <= r_partial - w_shifted;
      end
      if (r_idx != '0) begin
        r_idx <= r_idx - IW'(1);
      end
    end
  end

  assign resp_valid = (r_state == DONE);
  assign busy       = !w_idle;
  assign resp_id    = r_id;
  assign quotient   = r_quot;
  // The final partial remainder is < divisor, so its low N bits are exact.
  assign remainder  = r_partial[N-1:0];
  assign err        = r_err;

endmodule

// File: tb/tb_shared_divider_sched.sv
module tb_shared_divider_sched;

  localparam int M = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [M-1:0] req0_dividend = '0;
  logic [N-1:0] req0_divisor = '0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [M-1:0] req1_dividend = '0;
  logic [N-1:0] req1_divisor = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic         resp_id;
  logic [M-N:0] quotient;
  logic [N-1:0] remainder;
  logic         err;
  logic         busy;

  int total = 0;
  int bad = 0;

  shared_divider_sched #(.M(M), .N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_dividend (req0_dividend),
    .req0_divisor  (req0_divisor),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_dividend (req1_dividend),
    .req1_divisor  (req1_divisor),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .quotient      (quotient),
    .remainder     (remainder),
    .err           (err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rid;
    logic [M-1:0] dvd;
    logic [N-1:0] dvs;
    logic [M-N:0] q;
    logic [N-1:0] r;
    logic         e;
    int           lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_req(input logic rid, input logic v, input logic [M-1:0] dd,
                         input logic [N-1:0] ds);
    if (rid) begin
      req1_valid = v; req1_dividend = dd; req1_divisor = ds;
    end else begin
      req0_valid = v; req0_dividend = dd; req0_divisor = ds;
    end
  endtask

  // Entered at negedge+1 of the handshake cycle (cycle 0). Drops and scrambles
  // requester inputs, waits for the response, checks it, then checks the
  // return to IDLE (resp_ready assumed high).
  task automatic wait_resp(input string tag, input logic eid, input logic [M-N:0] eq,
                           input logic [N-1:0] er, input logic ee, input int elat);
    int  cyc;
    bit  seen;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_dividend = ~req0_dividend; req0_divisor = ~req0_divisor;
    req1_dividend = ~req1_dividend; req1_divisor = ~req1_divisor;
    cyc  = 1;
    seen = 1'b0;
    repeat (40) begin
      #1;
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, ".seen"}, 32'(seen), 1);
    check({tag, ".lat"}, cyc, elat);
    check({tag, ".q"}, 32'(quotient), 32'(eq));
    check({tag, ".r"}, 32'(remainder), 32'(er));
    check({tag, ".err"}, 32'(err), 32'(ee));
    check({tag, ".id"}, 32'(resp_id), 32'(eid));
    $display("%s: id=%0d q=%0d r=%0d err=%0d lat=%0d", tag, resp_id, quotient, remainder, err, cyc);
    @(negedge clk);
    #1;
    check({tag, ".idle"}, 32'(busy), 0);
  endtask

  task automatic run_op(input string tag, input vec_t v);
    set_req(v.rid, 1'b1, v.dvd, v.dvs);
    #1;
    check({tag, ".ready"}, 32'(v.rid ? req1_ready : req0_ready), 1);
    check({tag, ".other"}, 32'(v.rid ? req0_ready : req1_ready), 0);
    wait_resp(tag, v.rid, v.q, v.r, v.e, v.lat);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int   nresp;
    int   both_rdy;
    logic ids[3];
    logic [M-N:0] qs[3];
    logic [N-1:0] rs[3];
    bit   seen;

    //               rid   dividend  divisor  q       r      err  lat
    vecs[0] = '{1'b0, 8'd200, 4'd7,  5'd28, 4'd4, 1'b0, 6};
    vecs[1] = '{1'b1, 8'd250, 4'd3,  5'd31, 4'd0, 1'b1, 1};
    vecs[2] = '{1'b0, 8'd50,  4'd0,  5'd31, 4'd0, 1'b1, 1};
    vecs[3] = '{1'b1, 8'd255, 4'd15, 5'd17, 4'd0, 1'b0, 6};
    vecs[4] = '{1'b0, 8'd128, 4'd4,  5'd31, 4'd0, 1'b1, 1};
    vecs[5] = '{1'b1, 8'd127, 4'd4,  5'd31, 4'd3, 1'b0, 6};
    vecs[6] = '{1'b0, 8'd0,   4'd1,  5'd0,  4'd0, 1'b0, 6};
    vecs[7] = '{1'b1, 8'd5,   4'd9,  5'd0,  4'd5, 1'b0, 6};
    vecs[8] = '{1'b0, 8'd255, 4'd8,  5'd31, 4'd7, 1'b0, 6};

    // Reset state, with a requester asserting valid during reset
    rst = 1'b1;
    req0_valid = 1'b1; req0_dividend = 8'd200; req0_divisor = 4'd7;
    req1_valid = 1'b1; req1_dividend = 8'd45;  req1_divisor = 4'd6;
    @(negedge clk);
    #1;
    check("rst.ready0", 32'(req0_ready), 0);
    check("rst.ready1", 32'(req1_ready), 0);
    check("rst.vals", 32'({resp_valid, busy, resp_id, err, quotient, remainder}), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    // Table-driven operations
    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Round-robin with both requesters continuously valid after reset
    do_reset();
    set_req(1'b0, 1'b1, 8'd100, 4'd9);
    set_req(1'b1, 1'b1, 8'd45, 4'd6);
    nresp = 0;
    both_rdy = 0;
    repeat (60) begin
      #1;
      if (req0_ready && req1_ready) both_rdy++;
      if (resp_valid) begin
        ids[nresp] = resp_id; qs[nresp] = quotient; rs[nresp] = remainder;
        $display("rr resp %0d: id=%0d q=%0d r=%0d", nresp, resp_id, quotient, remainder);
        nresp++;
        if (nresp == 3) break;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr.count", nresp, 3);
    check("rr.onehot", both_rdy, 0);
    if (nresp == 3) begin
      check("rr.id0", 32'(ids[0]), 0);
      check("rr.q0", 32'(qs[0]), 11);
      check("rr.r0", 32'(rs[0]), 1);
      check("rr.id1", 32'(ids[1]), 1);
      check("rr.q1", 32'(qs[1]), 7);
      check("rr.r1", 32'(rs[1]), 3);
      check("rr.id2", 32'(ids[2]), 0);
      check("rr.q2", 32'(qs[2]), 11);
    end
    @(negedge clk);
    #1;
    check("rr.idle", 32'(busy), 0);

    // Back-pressure: hold DONE for 10 cycles while another requester waits
    resp_ready = 1'b0;
    set_req(1'b0, 1'b1, 8'd200, 4'd7);
    #1;
    check("hold.ready", 32'(req0_ready), 1);
    @(negedge clk);
    req0_valid = 1'b0;
    set_req(1'b1, 1'b1, 8'd45, 4'd6);
    seen = 1'b0;
    repeat (20) begin
      #1;
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("hold.seen", 32'(seen), 1);
    for (int k = 0; k < 10; k++) begin
      if (k != 0) begin
        @(negedge clk);
        #1;
      end
      // {resp_valid, busy, req0_ready, req1_ready, resp_id, err, quotient, remainder}
      check($sformatf("hold.c%0d", k),
            32'({resp_valid, busy, req0_ready, req1_ready, resp_id, err, quotient, remainder}),
            32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd28, 4'd4}));
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    check("hold.rel_valid", 32'(resp_valid), 1);
    check("hold.rel_noacc", 32'(req1_ready), 0);
    @(negedge clk);
    #1;
    check("hold.idle", 32'(busy), 0);
    check("hold.next_ready", 32'(req1_ready), 1);
    req1_valid = 1'b0;
    #1;

    // Reset in the third CALC cycle aborts; the pending requester is re-accepted
    @(negedge clk);
    set_req(1'b0, 1'b1, 8'd200, 4'd7);
    #1;
    check("abort.ready", 32'(req0_ready), 1);
    @(negedge clk);
    req0_dividend = 8'd100; req0_divisor = 4'd9;
    #1;
    check("abort.busy", 32'({busy, req0_ready}), 2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.rst_ready", 32'(req0_ready), 0);
    check("abort.no_resp", 32'(resp_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort.state", 32'({busy, resp_valid, quotient}), 0);
    check("abort.reaccept", 32'(req0_ready), 1);
    wait_resp("abort.fresh", 1'b0, 5'd11, 4'd1, 1'b0, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
